// File: rtl/tick_pwm.sv
// Tick-driven PWM with double-buffered period/duty; updates land only on a period boundary.
// Optional one-shot mode (single PWM cycle, then park in DONE) is enabled by defining PWM_ONESHOT_EN.
module tick_pwm #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             en,
   input  logic [WIDTH-1:0] period,
   input  logic [WIDTH-1:0] duty,
   input  logic             load,
`ifdef PWM_ONESHOT_EN
   input  logic             oneshot,
`endif
   output logic             pwm_out,
   output logic             period_done,
   output logic             pending
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1
`ifdef PWM_ONESHOT_EN
      , S_DONE = 2'd2
`endif
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] per_sh_q, per_sh_d;
   logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
   logic [WIDTH-1:0] per_st_q, per_st_d;
   logic [WIDTH-1:0] duty_st_q, duty_st_d;
   logic             pend_q, pend_d;
   logic             pwm_q, pwm_d;
   logic             done_q, done_d;
   logic             wrap;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      per_sh_d  = per_sh_q;
      duty_sh_d = duty_sh_q;
      per_st_d  = per_st_q;
      duty_st_d = duty_st_q;
      pend_d    = pend_q;
      done_d    = 1'b0;
      wrap      = tick && (cnt_q == per_sh_q);

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (load) begin
               per_sh_d  = period;
               duty_sh_d = duty;
            end
            if (en) state_d = S_RUN;
         end

         S_RUN: begin
            if (!en || wrap) begin
               // Boundary: a load on this edge beats anything still staged.
               if (load) begin
                  per_sh_d  = period;
                  duty_sh_d = duty;
               end else if (pend_q) begin
                  per_sh_d  = per_st_q;
                  duty_sh_d = duty_st_q;
               end
               pend_d = 1'b0;
               cnt_d  = '0;
               if (!en) begin
                  state_d = S_IDLE;
               end else begin
                  done_d = 1'b1;
`ifdef PWM_ONESHOT_EN
                  if (oneshot) state_d = S_DONE;
`endif
               end
            end else begin
               if (tick) cnt_d = cnt_q + 1'b1;
               if (load) begin
                  per_st_d  = period;
                  duty_st_d = duty;
                  pend_d    = 1'b1;
               end
            end
         end

`ifdef PWM_ONESHOT_EN
         S_DONE: begin
            cnt_d = '0;
            if (load) begin
               per_sh_d  = period;
               duty_sh_d = duty;
            end
            if (!en) state_d = S_IDLE;
         end
`endif

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Output follows the post-edge count and shadow duty, so it moves on the tick edge itself.
      pwm_d = (state_d == S_RUN) && (cnt_d < duty_sh_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         per_sh_q  <= '0;
         duty_sh_q <= '0;
         per_st_q  <= '0;
         duty_st_q <= '0;
         pend_q    <= 1'b0;
         pwm_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         per_sh_q  <= per_sh_d;
         duty_sh_q <= duty_sh_d;
         per_st_q  <= per_st_d;
         duty_st_q <= duty_st_d;
         pend_q    <= pend_d;
         pwm_q     <= pwm_d;
         done_q    <= done_d;
      end
   end

   assign pwm_out     = pwm_q;
   assign period_done = done_q;
   assign pending     = pend_q;

endmodule

// File: doc/tick_pwm.md
# tick_pwm

Tick-driven PWM generator that sits directly downstream of the prescaler `counter`, consuming its one-cycle `tick` strobe as the PWM time base. It counts ticks over a programmable period and drives a duty-cycle-controlled output. Period and duty are double-buffered, so software-side changes take effect only at a period boundary and never produce glitched or truncated pulses.

## Interface
- `WIDTH`, default 8: width of the period/duty counters.
- `clk`, input, 1: system clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `tick`, input, 1: one-cycle strobe from the prescaler; the only event that advances the PWM count.
- `en`, input, 1: run enable, level-sensitive.
- `period`, input, WIDTH: requested period, in ticks, minus 1. A value of N gives N+1 ticks per PWM cycle.
- `duty`, input, WIDTH: requested high time, in ticks.
- `load`, input, 1: one-cycle request to capture `period`/`duty` into the staging registers.
- `pwm_out`, output, 1: PWM waveform, registered.
- `period_done`, output, 1: one-cycle pulse on each wrap, registered.
- `pending`, output, 1: staged values are waiting for a period boundary.

## Operation
- **State machine states:** IDLE and RUN. DONE exists only when `PWM_ONESHOT_EN` is defined.
- **IDLE:**
  - `cnt` = 0, `pwm_out` = 0.
  - `load` writes `period`/`duty` straight into the shadow registers `per_sh`/`duty_sh`; `pending` stays 0.
  - `en` = 1 moves to RUN on the next edge.
- **RUN, on an edge with `tick` = 1:**
  - If `cnt` == `per_sh`: `cnt` ← 0, and `period_done` pulses for 1 cycle.
  - Otherwise: `cnt` ← `cnt` + 1.
- **RUN, on an edge with `tick` = 0:** `cnt` holds.
- **`pwm_out` rule:** `pwm_out` = (`cnt` < `duty_sh`), computed from post-edge values.
  - `duty_sh` = 0 gives constant low.
  - `duty_sh` > `per_sh` gives constant high.
- **`load` in RUN:** captures into the staging registers and sets `pending`.
  - At the next wrap, shadow ← staging and `pending` clears.
  - The new values govern the cycle starting at `cnt` = 0.
- **Simultaneous `load` and wrap:** the values presented with `load` go directly to the shadow registers, and `pending` clears. Older staged values are discarded.
- **Multiple `load` pulses before a wrap:** the last one wins.
- **`per_sh` = 0:** wrap on every tick, so `period_done` pulses on every tick. `pwm_out` is 1 iff `duty_sh` ≥ 1.
- **`en` falls in RUN:** go to IDLE on that edge.
  - `cnt` ← 0 and `pwm_out` ← 0.
  - `pending` and the staging registers are kept, and are applied to the shadows on that same edge.
- **Arithmetic:** all compares are unsigned and WIDTH bits wide. `cnt` never exceeds `per_sh`, so there is no overflow.

## Timing
- **Reset values:**
  - Outputs: `pwm_out` = 0, `period_done` = 0, `pending` = 0.
  - Internal: `cnt` = 0, `per_sh` = 0, `duty_sh` = 0, state = IDLE.
- **Reset precedence:** reset overrides every other input on the same edge, including mid-period.
- **IDLE→RUN latency:** 1 clock. The first `pwm_out` = 1 appears in the cycle after the IDLE→RUN edge when `duty_sh` ≥ 1, since `cnt` = 0.
- **Tick response:** `pwm_out`/`period_done` change on the same edge that samples `tick` = 1, with no extra latency.
- **Tick timing:** `tick` is assumed to be high for exactly 1 cycle per prescaler period. A `tick` held high advances the count once per clock.

## Configuration
- **`PWM_ONESHOT_EN` defined:**
  - Adds input `oneshot` (1 bit).
  - In RUN with `oneshot` = 1, a wrap moves the FSM to DONE instead of continuing; `period_done` still pulses.
  - DONE holds `cnt` = 0 and `pwm_out` = 0.
  - DONE returns to IDLE only when `en` = 0; `load` behaves as in IDLE.
- **`PWM_ONESHOT_EN` undefined:** no `oneshot` port and no DONE state; the block is free-running only.

## Test plan
- **Basic waveform:** reset, then `load` with `period` = 9, `duty` = 3 in IDLE, `en` = 1, `tick` every cycle → `pwm_out` is high 3 cycles and low 7, repeating; `period_done` pulses every 10 cycles.
- **Prescaled time base:** `tick` every 11 cycles (prescaler `psc` = 10), `period` = 4, `duty` = 2 → `pwm_out` is high 22 cycles and low 33; `period_done` pulses every 55 cycles.
- **Shadow update:** mid-period, `load` with `duty` = 7 → `pending` = 1; the current cycle finishes with 3 high ticks; from the next `cnt` = 0, 7 high ticks; `pending` clears on the wrap edge.
- **Duty extremes:** `duty` = 0 → `pwm_out` always 0; `duty` = 15 with `period` = 9 → always 1; `period` = 0, `duty` = 1 → `period_done` on every tick.
- **Boundary events:** `load` on the wrap edge → the new values apply immediately; `en` dropped at `cnt` = 5 → IDLE, `pwm_out` = 0 on that edge; reset asserted mid-period → all outputs 0 on the next edge.
- **One-shot (`PWM_ONESHOT_EN` defined):** `oneshot` = 1, `period` = 4, `duty` = 2 → exactly one pulse of 2 ticks, one `period_done`, then DONE with `pwm_out` = 0 until `en` = 0.
